// File: rtl/periph_pkg.sv
`default_nettype none
// ============================================================================
// Module      : periph_pkg
// Description : Shared constants and types for the peripheral bus master:
//               register map of the peripheral window and the command type.
// Revision    : 1.0 - initial release
// ============================================================================
package periph_pkg;

  localparam logic [31:0] PERIPH_BASE  = 32'h4000_0000;
  localparam logic [31:0] TH_ADDR      = 32'h4000_0000;
  localparam logic [31:0] TL_ADDR      = 32'h4000_0004;
  localparam logic [31:0] TCON_ADDR    = 32'h4000_0008;
  localparam logic [31:0] LED_ADDR     = 32'h4000_000C;
  localparam logic [31:0] DIGI_ADDR    = 32'h4000_0010;
  localparam logic [31:0] SYSTICK_ADDR = 32'h4000_0014;
  localparam logic [31:0] SELREG_ADDR  = 32'h4000_0018;

  // One queued request: 65 bits {write, addr, wdata}
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // Word-aligned and inside the inclusive [lo, hi] window
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi) && (addr[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/periph_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module      : periph_bus_master_if
// Description : Requester command/response handshakes plus peripheral bus.
//               master = the bus master block, slave = requester/peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
interface periph_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_write;
  logic        rsp_err;
  logic        bus_rd;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, bus_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err,
           bus_rd, bus_wr, bus_addr, bus_wdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, bus_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err,
           bus_rd, bus_wr, bus_addr, bus_wdata
  );
endinterface
`default_nettype wire

// File: rtl/periph_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : periph_cmd_fifo
// Description : Synchronous command FIFO, DEPTH entries (power of two).
//               Pointers carry one extra wrap bit; no push-to-pop bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module periph_cmd_fifo
  import periph_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output cmd_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  cmd_t        mem [DEPTH];

  // Advance pointers; protected against overflow/underflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array, not reset: contents are only visible through the pointers
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/periph_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : periph_bus_master
// Description : Queues requester commands, issues each as a one-cycle
//               rd/wr strobe on the peripheral bus and returns one in-order
//               response per command. One transaction in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module periph_bus_master
  import periph_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] LAST_ADDR = 32'h4000_0018
) (
  input  logic                       clk,
  input  logic                       reset,
  periph_bus_master_if.master        pif,
  output logic                       busy
);

  logic        fifo_full;
  logic        fifo_empty;
  cmd_t        fifo_head;
  cmd_t        cmd_in;
  logic        push;
  logic        pop;

  logic        stage_valid;
  logic        stage_legal;
  cmd_t        stage_cmd;

  logic        rsp_valid_q;
  logic        rsp_write_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  assign cmd_in = {pif.cmd_write, pif.cmd_addr, pif.cmd_wdata};
  assign push   = pif.cmd_valid && !fifo_full;
  // Pop only when nothing is outstanding once this edge's consume is counted
  assign pop    = !fifo_empty && !stage_valid && !(rsp_valid_q && !pif.rsp_ready);

  periph_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (cmd_in),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Bus stage: one-cycle occupancy; address/data hold after the transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_valid <= 1'b0;
      stage_legal <= 1'b0;
      stage_cmd   <= '0;
    end else begin
      stage_valid <= pop;
      if (pop) begin
        stage_cmd   <= fifo_head;
        stage_legal <= addr_legal(fifo_head.addr, BASE_ADDR, LAST_ADDR);
      end
    end
  end

  // Response register: capture at end of bus cycle, clear on consume
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (stage_valid) begin
      rsp_valid_q <= 1'b1;
      rsp_write_q <= stage_cmd.write;
      rsp_err_q   <= !stage_legal;
      rsp_rdata_q <= (!stage_cmd.write && stage_legal) ? pif.bus_rdata : 32'h0;
    end else if (rsp_valid_q && pif.rsp_ready) begin
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end
  end

  assign pif.cmd_ready = !fifo_full;
  assign pif.bus_rd    = stage_valid && !stage_cmd.write && stage_legal;
  assign pif.bus_wr    = stage_valid &&  stage_cmd.write && stage_legal;
  assign pif.bus_addr  = stage_cmd.addr;
  assign pif.bus_wdata = stage_cmd.wdata;
  assign pif.rsp_valid = rsp_valid_q;
  assign pif.rsp_write = rsp_write_q;
  assign pif.rsp_err   = rsp_err_q;
  assign pif.rsp_rdata = rsp_rdata_q;
  assign busy          = !fifo_empty || stage_valid || rsp_valid_q;

endmodule
`default_nettype wire
